// File: rtl/logic_unit_pipe_pkg.sv
// logic_unit_pkg: shared definitions for the pipelined bitwise logic unit.
//   OP_W     - opcode width (fixed at 3, not overridable)
//   MAX_W    - widest supported operand; helpers work at this width and
//              callers zero-extend and mask
//   lu_op_e  - opcode encoding
//   lu_eval  - bitwise evaluation of one opcode (used by RTL and bench model)
//   lu_parity- XOR reduction helper for the result parity flag
package logic_unit_pkg;

    localparam int OP_W  = 3;
    localparam int MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        LU_AND  = 3'd0,
        LU_OR   = 3'd1,
        LU_NAND = 3'd2,
        LU_NOR  = 3'd3,
        LU_XOR  = 3'd4,
        LU_XNOR = 3'd5,
        LU_NOT  = 3'd6,
        LU_ANDN = 3'd7
    } lu_op_e;

    // Bits above the caller's width may come back as ones (NOT/NAND/...),
    // so callers mask the result down to their own width.
    function automatic logic [MAX_W-1:0] lu_eval(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input lu_op_e op);
        logic [MAX_W-1:0] y;
        case (op)
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_NAND: y = ~(a & b);
            LU_NOR:  y = ~(a | b);
            LU_XOR:  y = a ^ b;
            LU_XNOR: y = ~(a ^ b);
            LU_NOT:  y = ~a;
            LU_ANDN: y = a & ~b;
            default: y = {MAX_W{1'b0}};
        endcase
        return y;
    endfunction

    function automatic logic lu_parity(input logic [MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_core.sv
// logic_unit_core: purely combinational WIDTH-bit op evaluator with flags.
//   a, b     in  WIDTH  operands
//   op       in  lu_op_e opcode
//   y        out WIDTH  result
//   zero     out 1      y == 0
//   parity   out 1      XOR reduction of y
//   red_and  out 1      &y  (only with LOGIC_UNIT_PIPE_REDUCE_EN)
//   red_or   out 1      |y  (only with LOGIC_UNIT_PIPE_REDUCE_EN)
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  lu_op_e           op,
    output logic [WIDTH-1:0] y,
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    output logic             red_and,
    output logic             red_or,
`endif
    output logic             zero,
    output logic             parity
);

    // Keeps only the low WIDTH bits of the full-width evaluation.
    localparam logic [MAX_W-1:0] W_MASK = {MAX_W{1'b1}} >> (MAX_W - WIDTH);

    logic [MAX_W-1:0] a_ext_s;
    logic [MAX_W-1:0] b_ext_s;
    logic [MAX_W-1:0] res_s;

    // Zero-extend, evaluate at full width, mask and derive the flags.
    always_comb begin
        a_ext_s            = {MAX_W{1'b0}};
        b_ext_s            = {MAX_W{1'b0}};
        a_ext_s[WIDTH-1:0] = a;
        b_ext_s[WIDTH-1:0] = b;
        res_s              = lu_eval(a_ext_s, b_ext_s, op) & W_MASK;
        y                  = res_s[WIDTH-1:0];
        zero               = (res_s == {MAX_W{1'b0}});
        parity             = lu_parity(res_s);
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
        red_and            = &res_s[WIDTH-1:0];
        red_or             = |res_s;
`endif
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides (capacity 2 beats, strict FIFO order).
// Optional macro: LOGIC_UNIT_PIPE_REDUCE_EN adds out_red_and / out_red_or.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; in_a, in_b, in_op operands
//   out_valid/out_ready  result handshake; out_y result
//   out_zero, out_parity result flags, registered with out_y
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    output logic             out_red_and,
    output logic             out_red_or,
`endif
    output logic             out_zero,
    output logic             out_parity
);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    lu_op_e           s1_op_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_y_r;
    logic             s2_zero_r;
    logic             s2_parity_r;

    logic             advance1_s;
    logic             advance2_s;
    logic             accept_s;

    logic [WIDTH-1:0] core_y_s;
    logic             core_zero_s;
    logic             core_parity_s;

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    logic             s2_red_and_r;
    logic             s2_red_or_r;
    logic             core_red_and_s;
    logic             core_red_or_s;
`endif

    // Each stage moves when its downstream slot is empty or being drained;
    // in_ready is built from registered state and out_ready only.
    always_comb begin
        advance2_s = !s2_valid_r || out_ready;
        advance1_s = !s1_valid_r || advance2_s;
        accept_s   = in_valid && advance1_s;
    end

    assign in_ready = advance1_s;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a       (s1_a_r),
        .b       (s1_b_r),
        .op      (s1_op_r),
        .y       (core_y_s),
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
        .red_and (core_red_and_s),
        .red_or  (core_red_or_s),
`endif
        .zero    (core_zero_s),
        .parity  (core_parity_s)
    );

    // Stage 1: operand capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= LU_AND;
        end else begin
            if (advance1_s) begin
                s1_valid_r <= in_valid;
            end
            if (accept_s) begin
                s1_a_r  <= in_a;
                s1_b_r  <= in_b;
                s1_op_r <= lu_op_e'(in_op);
            end
        end
    end

    // Stage 2: result and flags; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_y_r      <= {WIDTH{1'b0}};
            s2_zero_r   <= 1'b1;
            s2_parity_r <= 1'b0;
        end else begin
            if (advance2_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_y_r      <= core_y_s;
                    s2_zero_r   <= core_zero_s;
                    s2_parity_r <= core_parity_s;
                end
            end
        end
    end

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    // Stage 2 reduction flags, updated under the same condition as the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_red_and_r <= 1'b0;
            s2_red_or_r  <= 1'b0;
        end else begin
            if (advance2_s && s1_valid_r) begin
                s2_red_and_r <= core_red_and_s;
                s2_red_or_r  <= core_red_or_s;
            end
        end
    end

    assign out_red_and = s2_red_and_r;
    assign out_red_or  = s2_red_or_r;
`endif

    assign out_valid  = s2_valid_r;
    assign out_y      = s2_y_r;
    assign out_zero   = s2_zero_r;
    assign out_parity = s2_parity_r;

endmodule
